fifo_rr_sched: RTL and testbench

- Round-robin drain scheduler for a bank of NUM_Q standard FIFOs with registered output and 1-cycle read latency.
- Issues pop strobes to the queues and merges their data into one valid/ready stream tagged with the source queue index.
- Uses bounded bursts for fairness and an internal 2-entry output buffer so that downstream backpressure never causes a FIFO over-read.
- Sits between the per-channel input FIFOs and the shared delta-compute datapath.

---
 rtl/fifo_rr_sched.sv | 137 +++++++++++++
 tb/tb_fifo_rr_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin burst drain of NUM_Q FIFOs into one valid/ready stream via a 2-entry output buffer.
// Define FIFO_RR_SCHED_CHECK_EN to compile in simulation-only protocol checks.
module fifo_rr_sched #(
    parameter int  NUM_Q     = 4,
    parameter int  WIDTH     = 16,
    parameter int  MAX_BURST = 4,
    localparam int QID_BW    = $clog2(NUM_Q),
    localparam int BCNT_BW   = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_Q-1:0]       q_empty,
    output logic [NUM_Q-1:0]       q_pop,
    input  logic [NUM_Q*WIDTH-1:0] q_dout,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic [QID_BW-1:0]      m_qid
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nx;
    logic [QID_BW-1:0]   ptr, ptr_nx, gnt, gnt_nx, base, sel, pop_id, inf_id, gnt_inc;
    logic [BCNT_BW-1:0]  cnt, cnt_nx;
    logic [1:0]          occ;
    logic                inflight, rd_ptr, wr_ptr, pop_go, found, term, cont, xfer, credit;
    logic [WIDTH-1:0]    ob_data [2];
    logic [QID_BW-1:0]   ob_qid  [2];

    function automatic logic [QID_BW-1:0] wrap_add(input logic [QID_BW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        return QID_BW'(s >= NUM_Q ? s - NUM_Q : s);
    endfunction

    assign gnt_inc = wrap_add(gnt, 1);
    assign term    = (state == BURST) && (q_empty[gnt] || cnt == BCNT_BW'(MAX_BURST));
    assign cont    = (state == BURST) && !term;
    assign base    = term ? gnt_inc : ptr;
    assign xfer    = m_valid && m_ready;
    // Counting the in-flight pop keeps the 2-entry buffer from ever overflowing.
    assign credit  = (3'(occ) + 3'(inflight) - 3'(xfer)) < 3'd2;
    assign wr_ptr  = rd_ptr ^ occ[0];
    assign m_valid = occ != 2'd0;
    assign m_data  = ob_data[rd_ptr];
    assign m_qid   = ob_qid[rd_ptr];

    always_comb begin
        sel   = base;
        found = 1'b0;
        for (int k = NUM_Q - 1; k >= 0; k--)
            if (!q_empty[wrap_add(base, k)]) begin
                sel   = wrap_add(base, k);
                found = 1'b1;
            end
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            gnt   <= gnt_nx;
            cnt   <= cnt_nx;
        end

    always_comb begin
        state_nx = state;
        ptr_nx   = term ? gnt_inc : ptr;
        gnt_nx   = gnt;
        cnt_nx   = cnt;
        if (pop_go) begin
            state_nx = BURST;
            gnt_nx   = pop_id;
            cnt_nx   = cont ? cnt + 1'b1 : BCNT_BW'(1);
        end else if (!cont) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    always_comb begin
        pop_id = cont ? gnt : sel;
        pop_go = rstn && credit && (cont || found);
        q_pop  = pop_go ? NUM_Q'(1) << pop_id : '0;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            occ      <= '0;
            inflight <= 1'b0;
            inf_id   <= '0;
            rd_ptr   <= 1'b0;
            ob_data  <= '{default: '0};
            ob_qid   <= '{default: '0};
        end else begin
            inflight <= pop_go;
            inf_id   <= pop_id;
            occ      <= occ + 2'(inflight) - 2'(xfer);
            if (xfer) rd_ptr <= ~rd_ptr;
            if (inflight) begin
                ob_data[wr_ptr] <= q_dout[int'(inf_id)*WIDTH +: WIDTH];
                ob_qid[wr_ptr]  <= inf_id;
            end
        end

`ifdef FIFO_RR_SCHED_CHECK_EN
`ifndef SYNTHESIS
    logic              stall_q;
    logic [WIDTH-1:0]  data_q;
    logic [QID_BW-1:0] qid_q;
    int                starve [NUM_Q];

    always @(posedge clk) begin
        if (rstn) begin
            if ((q_pop & q_empty) != '0) $display("[!!!] @%0t %m pop to empty queue", $time);
            if ($countones(q_pop) > 1) $display("[!!!] @%0t %m multiple q_pop bits high", $time);
            if (3'(occ) + 3'(inflight) > 3'd2) $display("[!!!] @%0t %m output buffer overflow", $time);
            if (stall_q && (m_data != data_q || m_qid != qid_q)) $display("[!!!] @%0t %m output changed while stalled", $time);
            for (int i = 0; i < NUM_Q; i++) begin
                starve[i] <= (q_empty[i] || q_pop[i] || !m_ready) ? 0 : starve[i] + 1;
                if (starve[i] == NUM_Q*MAX_BURST*4) $display("[!!!] @%0t %m queue %0d starved", $time, i);
            end
        end
        stall_q <= rstn && m_valid && !m_ready;
        data_q  <= m_data;
        qid_q   <= m_qid;
    end

    final if (occ != 2'd0 || inflight) $display("[!!!] @%0t %m occ=%0d inflight=%0d at end of simulation", $time, occ, inflight);
`endif
`endif
endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched: two lanes (MAX_BURST 4 and 1) driven by identical FIFO contents,
// compared word-by-word against a burst-level round-robin model.
module tb_fifo_rr_sched;
    localparam int NQ = 4;
    localparam int W  = 16;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           m_ready = 1'b1;
    logic [NQ-1:0]  q_empty [2];
    logic [NQ-1:0]  q_pop [2];
    logic [NQ*W-1:0] q_dout [2];
    logic           m_valid [2];
    logic [W-1:0]   m_data [2];
    logic [1:0]     m_qid [2];

    logic [W-1:0]   qmem [2][NQ][$];
    logic [W+1:0]   obs [2][$];
    logic [W+1:0]   exp_w [2][$];
    int             obs_cyc [2][$];
    int             npop [2], first_pop [2], last_pop [2];
    int             bad_pop [2], multi [2], over [2];
    int             cyc, rmode, n_tests, n_fail;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_lane
        fifo_rr_sched #(.NUM_Q(NQ), .WIDTH(W), .MAX_BURST(g == 0 ? 4 : 1)) u_dut (
            .clk     (clk),
            .rstn    (rstn),
            .q_empty (q_empty[g]),
            .q_pop   (q_pop[g]),
            .q_dout  (q_dout[g]),
            .m_valid (m_valid[g]),
            .m_ready (m_ready),
            .m_data  (m_data[g]),
            .m_qid   (m_qid[g])
        );
    end

    function automatic logic ready_at(input int c);
        return rmode == 0 ? 1'b1 : rmode == 1 ? (c % 4 == 0 || c % 4 == 3) :
               rmode == 2 ? 1'($urandom % 2) : 1'b0;
    endfunction

    task automatic set_mode(input int m);
        rmode   = m;
        m_ready = ready_at(cyc);
    endtask

    task automatic upd_empty();
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < NQ; i++) q_empty[l][i] = (qmem[l][i].size() == 0);
    endtask

    task automatic clear_obs();
        for (int l = 0; l < 2; l++) begin
            obs[l].delete();
            obs_cyc[l].delete();
            exp_w[l].delete();
            npop[l] = 0;
            first_pop[l] = -1;
            last_pop[l] = -1;
        end
        cyc = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < NQ; i++) qmem[l][i].delete();
            q_dout[l] = '0;
        end
        upd_empty();
        set_mode(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        clear_obs();
    endtask

    task automatic fill(input int i, input int n);
        logic [W-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = W'($urandom);
            qmem[0][i].push_back(d);
            qmem[1][i].push_back(d);
        end
        upd_empty();
    endtask

    // One clock: sample DUT at the falling edge, then act as the FIFOs just after the rising edge.
    task automatic step();
        logic [NQ-1:0] pv [2];
        int pend;
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            pv[l] = q_pop[l];
            if ((q_pop[l] & q_empty[l]) != '0) bad_pop[l]++;
            if ($countones(q_pop[l]) > 1) multi[l]++;
            if (q_pop[l] != '0) begin
                npop[l]++;
                if (first_pop[l] < 0) first_pop[l] = cyc;
                last_pop[l] = cyc;
            end
            if (m_valid[l] && m_ready) begin
                obs[l].push_back({m_qid[l], m_data[l]});
                obs_cyc[l].push_back(cyc);
            end
            pend = npop[l] - obs[l].size();
            if (pend > 2) over[l]++;
        end
        @(posedge clk); #1;
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < NQ; i++)
                if (pv[l][i] && qmem[l][i].size() > 0) q_dout[l][i*W +: W] = qmem[l][i].pop_front();
        upd_empty();
        cyc++;
        m_ready = ready_at(cyc);
    endtask

    // Expected stream: bursts of up to MAX_BURST words, next search starting after the granted queue.
    task automatic model();
        for (int l = 0; l < 2; l++) begin
            int pos [NQ];
            int base, q, maxb;
            pos  = '{default: 0};
            base = 0;
            maxb = (l == 0) ? 4 : 1;
            exp_w[l].delete();
            forever begin
                q = -1;
                for (int k = 0; k < NQ; k++) begin
                    int j;
                    j = (base + k) % NQ;
                    if (q < 0 && pos[j] < qmem[l][j].size()) q = j;
                end
                if (q < 0) break;
                for (int n = 0; n < maxb && pos[q] < qmem[l][q].size(); n++) begin
                    exp_w[l].push_back({2'(q), qmem[l][q][pos[q]]});
                    pos[q]++;
                end
                base = (q + 1) % NQ;
            end
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (n < budget && !(obs[0].size() >= exp_w[0].size() && obs[1].size() >= exp_w[1].size())) begin
            step();
            n++;
        end
        repeat (4) step();
    endtask

    function automatic int diff(input int l);
        if (obs[l].size() != exp_w[l].size()) return -2;
        foreach (obs[l][k]) if (obs[l][k] !== exp_w[l][k]) return k;
        return -1;
    endfunction

    task automatic test_reset();
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < NQ; i++) qmem[l][i].delete();
            q_dout[l] = '0;
        end
        fill(1, 2);
        set_mode(0);
        @(posedge clk); #1;
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if ({q_pop[l], m_valid[l], m_data[l], m_qid[l]} !== '0) begin
                n_fail++;
                $display("FAIL reset lane%0d: pop=%b valid=%b data=%h qid=%0d, required all zero", l, q_pop[l], m_valid[l], m_data[l], m_qid[l]);
            end
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        clear_obs();
        model();
        run(50);
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (diff(l) != -1) begin
                n_fail++;
                $display("FAIL post_reset lane%0d: %0d words (diff at %0d), required %0d", l, obs[l].size(), diff(l), exp_w[l].size());
            end
        end
    endtask

    task automatic test_full_rate();
        int bad;
        do_reset();
        for (int i = 0; i < NQ; i++) fill(i, 8);
        model();
        run(200);
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (diff(l) != -1) begin
                n_fail++;
                $display("FAIL full_rate lane%0d: %0d words (diff at %0d), required %0d", l, obs[l].size(), diff(l), exp_w[l].size());
            end
            bad = 0;
            foreach (obs[l][k]) if (obs[l][k][W+1:W] != 2'(l == 0 ? (k / 4) % 4 : k % 4)) bad++;
            n_tests++;
            if (bad != 0 || obs[l].size() != 32) begin
                n_fail++;
                $display("FAIL full_rate_qid lane%0d: %0d bad qids of %0d words, required 0 of 32", l, bad, obs[l].size());
            end
            n_tests++;
            if (obs_cyc[l].size() != 32 || obs_cyc[l][0] != 2 || obs_cyc[l][31] != 33) begin
                n_fail++;
                $display("FAIL full_rate_timing lane%0d: first=%0d last=%0d n=%0d, required 2 33 32", l, obs_cyc[l][0], obs_cyc[l][obs_cyc[l].size()-1], obs_cyc[l].size());
            end
        end
    endtask

    task automatic test_single_queue();
        do_reset();
        fill(2, 10);
        model();
        run(100);
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (diff(l) != -1) begin
                n_fail++;
                $display("FAIL single_queue lane%0d: %0d words (diff at %0d), required %0d", l, obs[l].size(), diff(l), exp_w[l].size());
            end
            n_tests++;
            if (obs_cyc[l].size() != 10 || obs_cyc[l][9] - obs_cyc[l][0] != 9) begin
                n_fail++;
                $display("FAIL single_queue_gapless lane%0d: span=%0d n=%0d, required 9 10", l, obs_cyc[l][obs_cyc[l].size()-1] - obs_cyc[l][0], obs_cyc[l].size());
            end
        end
    endtask

    task automatic test_early_end();
        do_reset();
        fill(1, 2);
        fill(3, 4);
        model();
        run(100);
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (diff(l) != -1) begin
                n_fail++;
                $display("FAIL early_end lane%0d: %0d words (diff at %0d), required %0d", l, obs[l].size(), diff(l), exp_w[l].size());
            end
            n_tests++;
            if (npop[l] != 6 || last_pop[l] - first_pop[l] != 5) begin
                n_fail++;
                $display("FAIL early_end_pops lane%0d: pops=%0d span=%0d, required 6 5", l, npop[l], last_pop[l] - first_pop[l]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < NQ; i++) fill(i, 8);
        set_mode(1);
        model();
        run(400);
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (diff(l) != -1) begin
                n_fail++;
                $display("FAIL backpressure lane%0d: %0d words (diff at %0d), required %0d", l, obs[l].size(), diff(l), exp_w[l].size());
            end
        end
    endtask

    task automatic test_alternate();
        int bad;
        do_reset();
        fill(0, 6);
        fill(1, 6);
        model();
        run(100);
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (diff(l) != -1) begin
                n_fail++;
                $display("FAIL alternate lane%0d: %0d words (diff at %0d), required %0d", l, obs[l].size(), diff(l), exp_w[l].size());
            end
        end
        bad = 0;
        foreach (obs[1][k]) if (obs[1][k][W+1:W] != 2'(k % 2)) bad++;
        n_tests++;
        if (bad != 0 || obs_cyc[1].size() != 12 || obs_cyc[1][11] - obs_cyc[1][0] != 11) begin
            n_fail++;
            $display("FAIL alternate_rr: bad=%0d n=%0d, required 0 bad over 12 consecutive words", bad, obs_cyc[1].size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill(0, 3);
        fill(2, 6);
        set_mode(3);
        repeat (4) step();
        n_tests++;
        if (m_valid[0] !== 1'b1 || npop[0] != 2) begin
            n_fail++;
            $display("FAIL async_pre: valid=%b pops=%0d, required 1 2", m_valid[0], npop[0]);
        end
        #2 rstn = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if ({q_pop[l], m_valid[l], m_data[l], m_qid[l]} !== '0) begin
                n_fail++;
                $display("FAIL async_reset lane%0d: pop=%b valid=%b data=%h qid=%0d, required all zero", l, q_pop[l], m_valid[l], m_data[l], m_qid[l]);
            end
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        clear_obs();
        set_mode(0);
        model();
        run(100);
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (diff(l) != -1 || obs[l][0][W+1:W] != 2'd0) begin
                n_fail++;
                $display("FAIL async_resume lane%0d: %0d words (diff at %0d) first qid %0d, required %0d words from qid 0", l, obs[l].size(), diff(l), obs[l][0][W+1:W], exp_w[l].size());
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            do_reset();
            for (int i = 0; i < NQ; i++) fill(i, $urandom_range(0, 10));
            set_mode($urandom_range(0, 2));
            model();
            run(600);
            for (int l = 0; l < 2; l++) begin
                n_tests++;
                if (diff(l) != -1) begin
                    n_fail++;
                    $display("FAIL random it%0d lane%0d: %0d words (diff at %0d), required %0d", it, l, obs[l].size(), diff(l), exp_w[l].size());
                end
            end
        end
    endtask

    task automatic test_protocol();
        for (int l = 0; l < 2; l++) begin
            n_tests++;
            if (bad_pop[l] != 0 || multi[l] != 0 || over[l] != 0) begin
                n_fail++;
                $display("FAIL protocol lane%0d: empty_pops=%0d multi_pops=%0d over2=%0d, required 0 0 0", l, bad_pop[l], multi[l], over[l]);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rmode   = 0;
        bad_pop = '{0, 0};
        multi   = '{0, 0};
        over    = '{0, 0};
        test_reset();
        test_full_rate();
        test_single_queue();
        test_early_end();
        test_backpressure();
        test_alternate();
        test_async_reset();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
